seq_checker: RTL and testbench
==============================

Name: seq_checker

Overview:
- Responder end of the FSM check handshake: the FSM drives check_round and player_turn; this block returns result and empty.
- Stores the colour sequence appended by the colour generator.
- During the player's turn, compares each button press against the stored sequence for the current round.
- Reports pass/fail (result) and round-complete (empty) back to the game FSM.

Parameters:
DEPTH, 32, maximum sequence length in entries; must equal 2**RW
RW, 5, round index width; matches the FSM check_round bus
CW, 2, colour code width (4 colours)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous sequence wipe, pulse; driven from rst_seedgen
load_colour  in  1  append-strobe, one cycle per colour
colour_in  in  CW  colour appended on load_colour
check_round  in  RW  current round index from FSM; round r expects r+1 presses
player_turn  in  1  high while the player is entering the sequence
btn_valid  in  1  one-cycle press strobe, already debounced
btn_colour  in  CW  colour of press, valid with btn_valid
result  out  1  1 = no mismatch so far this turn; 0 = failed or idle-after-reset
empty  out  1  1 = all expected presses for the round consumed (or failed)
full  out  1  sequence store holds DEPTH entries
seq_len  out  RW+1  number of stored entries, 0..DEPTH

Behaviour:
- Reset (async, rst=1): state=IDLE; seq_len=0; idx=0; result=0; empty=0; full=0. Store contents are don't-care.
- Store: DEPTH x CW register array plus write count seq_len.
  - load_colour with seq_len<DEPTH: mem[seq_len]<=colour_in; seq_len+1 next cycle.
  - load_colour with seq_len==DEPTH: ignored, no wrap.
  - full = (seq_len==DEPTH), registered with seq_len.
  - clear: seq_len<=0, state<=IDLE, result<=0, empty<=0. clear beats load_colour in the same cycle.
  - Appends are accepted in every state.
- Turn start: rising edge of player_turn, detected against a registered copy (1-cycle delay).
  - On that edge: latch target=check_round+1 (RW+1 bits, no overflow) and set idx=0.
  - If target<=seq_len: state->CHECK, result=1, empty=0.
  - Else: state->FAIL, result=0, empty=1.
  - Outputs update the cycle after the edge is seen.
- States and transitions:
  - IDLE: ignore btn_valid. On player_turn rise, go as per turn start.
  - CHECK, on btn_valid:
    - btn_colour==mem[idx] and idx+1==target: state->PASS, empty=1, result stays 1.
    - btn_colour==mem[idx] otherwise: idx+1.
    - btn_colour!=mem[idx]: state->FAIL, result=0, empty=1.
  - CHECK, player_turn falls (no press that cycle): state->IDLE; result and empty hold their values.
  - PASS / FAIL: btn_valid ignored; result and empty sticky. On player_turn fall, go to IDLE (outputs hold). A new player_turn rise restarts the check.
- Latency: btn_valid in cycle N gives result/empty updated at the clock edge ending cycle N (visible cycle N+1). Exactly one press is consumed per strobe.
- Comparison reads mem[idx] combinationally.
- check_round changes during CHECK are ignored; target is latched.
- btn_valid in the same cycle as player_turn fall: the press is evaluated, then state->IDLE. If that press completes or fails the turn, the outputs reflect it.
- load_colour during CHECK at an index < target is permitted but undefined for game purposes. The FSM must not do it.
- Reset asserted mid-turn: immediate return to reset values; no partial state is retained.

Test Plan:
- Reset then idle: assert rst for 3 cycles -> result=0, empty=0, seq_len=0, full=0. btn_valid pulses in IDLE leave everything unchanged.
- Load and pass: load colours 2,0,3; check_round=2; raise player_turn; press 2,0,3 -> after 3rd press result=1, empty=1. After the 1st and 2nd presses, empty=0.
- Mismatch: same sequence, check_round=2; press 2,1 -> the cycle after the 2nd press, result=0, empty=1. A further press of 3 leaves the outputs unchanged.
- Round beyond stored length: seq_len=3, check_round=5, player_turn rise -> result=0, empty=1 one cycle later, with no presses.
- Full / overflow: 33 load_colour pulses -> seq_len=32, full=1, and mem[31] holds the 32nd colour. Then clear together with load_colour -> seq_len=0, full=0.
- Async reset mid-CHECK: after 1 correct press, pulse rst between clock edges -> outputs go to reset values immediately. A new turn after reloading starts at idx=0.

Source files
------------

// File: rtl/seq_checker_if.sv
// Check handshake between the game FSM (master) and the sequence checker (slave).
// The FSM drives check_round/player_turn and reads back result/empty.
interface seq_checker_if #(
  parameter int RW = 5
);
  logic [RW-1:0] check_round;
  logic          player_turn;
  logic          result;
  logic          empty;

  modport master (output check_round, output player_turn, input result, input empty);
  modport slave  (input check_round, input player_turn, output result, output empty);
endinterface

// File: rtl/seq_checker.sv
// Colour-sequence store and per-press checker for the game FSM.
// A turn starts on a player_turn rise and ends on pass, mismatch or player_turn fall.
module seq_checker #(
  parameter int DEPTH = 32,
  parameter int RW    = 5,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load_colour,
  input  logic [CW-1:0] colour_in,
  input  logic          btn_valid,
  input  logic [CW-1:0] btn_colour,
  output logic          full,
  output logic [RW:0]   seq_len,
  seq_checker_if.slave  hs
);

  localparam logic [RW:0] DEPTH_L = (RW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_PASS, S_FAIL} state_t;

  logic [CW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [RW-1:0] idx_q, idx_d;
  logic [RW:0]   target_q, target_d;
  logic          result_q, result_d;
  logic          empty_q, empty_d;
  logic [RW:0]   seq_len_q, seq_len_d;
  logic          full_q;
  logic          player_turn_p1;

  logic          turn_rise, turn_fall;
  logic [RW:0]   target_new;
  logic          start_ok;
  logic          hit, last;
  logic          do_write;

  assign turn_rise  = hs.player_turn & ~player_turn_p1;
  assign turn_fall  = ~hs.player_turn & player_turn_p1;
  assign target_new = {1'b0, hs.check_round} + (RW+1)'(1);
  assign start_ok   = (target_new <= seq_len_q);
  assign hit        = (btn_colour == mem[idx_q]);
  assign last       = (({1'b0, idx_q} + (RW+1)'(1)) == target_q);
  assign do_write   = load_colour & ~clear & ~full_q;

  assign seq_len_d  = clear ? '0 : (do_write ? seq_len_q + (RW+1)'(1) : seq_len_q);

  // Stage boundary: all control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      target_q       <= '0;
      result_q       <= 1'b0;
      empty_q        <= 1'b0;
      seq_len_q      <= '0;
      full_q         <= 1'b0;
      player_turn_p1 <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      target_q       <= target_d;
      result_q       <= result_d;
      empty_q        <= empty_d;
      seq_len_q      <= seq_len_d;
      full_q         <= (seq_len_d == DEPTH_L);
      player_turn_p1 <= hs.player_turn;
    end
  end

  // Storage array carries data only, so it is written without reset
  always_ff @(posedge clk) begin
    if (do_write) mem[seq_len_q[RW-1:0]] <= colour_in;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    target_d = target_q;
    if (clear) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else if (turn_rise) begin
      target_d = target_new;
      idx_d    = '0;
      state_d  = start_ok ? S_CHECK : S_FAIL;
    end else begin
      if (state_q == S_CHECK && btn_valid) begin
        if (!hit)      state_d = S_FAIL;
        else if (last) state_d = S_PASS;
        else           idx_d   = idx_q + RW'(1);
      end
      // A press in the same cycle as the fall is still judged above
      if (turn_fall) state_d = S_IDLE;
    end
  end

  always_comb begin
    result_d = result_q;
    empty_d  = empty_q;
    if (clear) begin
      result_d = 1'b0;
      empty_d  = 1'b0;
    end else if (turn_rise) begin
      result_d = start_ok;
      empty_d  = ~start_ok;
    end else if (state_q == S_CHECK && btn_valid) begin
      if (!hit) begin
        result_d = 1'b0;
        empty_d  = 1'b1;
      end else if (last) begin
        empty_d  = 1'b1;
      end
    end
  end

  assign hs.result = result_q;
  assign hs.empty  = empty_q;
  assign full      = full_q;
  assign seq_len   = seq_len_q;

endmodule

// File: tb/tb_seq_checker.sv
// Directed plus randomized bench for seq_checker against a queue-based turn model.
module tb_seq_checker;

  localparam int DEPTH = 32;
  localparam int RW    = 5;
  localparam int CW    = 2;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          load_colour;
  logic [CW-1:0] colour_in;
  logic          btn_valid;
  logic [CW-1:0] btn_colour;
  logic          full;
  logic [RW:0]   seq_len;

  seq_checker_if #(.RW(RW)) hs ();

  seq_checker #(.DEPTH(DEPTH), .RW(RW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .load_colour (load_colour),
    .colour_in   (colour_in),
    .btn_valid   (btn_valid),
    .btn_colour  (btn_colour),
    .full        (full),
    .seq_len     (seq_len),
    .hs          (hs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: stored colours, turn progress and verdict
  int q[$];
  int m_pos;
  int m_target;
  bit m_active;
  bit m_result;
  bit m_empty;
  bit pt_prev;

  task automatic model_reset();
    q.delete();
    m_pos    = 0;
    m_target = 0;
    m_active = 0;
    m_result = 0;
    m_empty  = 0;
    pt_prev  = 0;
  endtask

  task automatic model_step();
    bit rise, fall;
    if (rst) begin
      model_reset();
      return;
    end
    rise = hs.player_turn && !pt_prev;
    fall = !hs.player_turn && pt_prev;
    pt_prev = hs.player_turn;
    if (clear) begin
      q.delete();
      m_active = 0;
      m_result = 0;
      m_empty  = 0;
      return;
    end
    if (rise) begin
      m_target = int'(hs.check_round) + 1;
      m_pos    = 0;
      if (m_target <= q.size()) begin
        m_active = 1; m_result = 1; m_empty = 0;
      end else begin
        m_active = 0; m_result = 0; m_empty = 1;
      end
    end else if (m_active && btn_valid) begin
      if (int'(btn_colour) == q[m_pos]) begin
        m_pos++;
        if (m_pos == m_target) begin
          m_active = 0; m_empty = 1;
        end
      end else begin
        m_active = 0; m_result = 0; m_empty = 1;
      end
    end
    if (fall) m_active = 0;
    if (load_colour && q.size() < DEPTH) q.push_back(int'(colour_in));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".result"},  32'(hs.result), 32'(m_result));
    chk({tag, ".empty"},   32'(hs.empty),  32'(m_empty));
    chk({tag, ".seq_len"}, 32'(seq_len),   32'(q.size()));
    chk({tag, ".full"},    32'(full),      32'(q.size() == DEPTH));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    load_colour = 0;
    btn_valid   = 0;
    clear       = 0;
  endtask

  task automatic load(input int c);
    load_colour = 1;
    colour_in   = CW'(c);
    tick("load");
  endtask

  task automatic press(input int c, input string tag);
    btn_valid  = 1;
    btn_colour = CW'(c);
    tick(tag);
  endtask

  initial begin
    rst = 1; clear = 0; load_colour = 0; colour_in = '0;
    btn_valid = 0; btn_colour = '0;
    hs.player_turn = 0; hs.check_round = '0;
    model_reset();

    // Reset held for three cycles, then presses in IDLE do nothing
    repeat (3) tick("reset");
    chk("reset.result", 32'(hs.result), 0);
    chk("reset.seq_len", 32'(seq_len), 0);
    rst = 0;
    repeat (3) press($urandom_range(0, 3), "idle_btn");
    chk("idle_btn.empty", 32'(hs.empty), 0);

    // Load 2,0,3 and play round 2 correctly
    load(2); load(0); load(3);
    hs.check_round = 5'd2; hs.player_turn = 1;
    tick("pass.start");
    chk("pass.start.result", 32'(hs.result), 1);
    press(2, "pass.p1");
    chk("pass.p1.empty", 32'(hs.empty), 0);
    press(0, "pass.p2");
    chk("pass.p2.empty", 32'(hs.empty), 0);
    press(3, "pass.p3");
    chk("pass.p3.result", 32'(hs.result), 1);
    chk("pass.p3.empty", 32'(hs.empty), 1);
    hs.player_turn = 0;
    tick("pass.end");

    // Mismatch on the second press, later press ignored
    hs.player_turn = 1;
    tick("mm.start");
    press(2, "mm.p1");
    press(1, "mm.p2");
    chk("mm.p2.result", 32'(hs.result), 0);
    chk("mm.p2.empty", 32'(hs.empty), 1);
    press(3, "mm.p3");
    chk("mm.p3.result", 32'(hs.result), 0);
    chk("mm.p3.empty", 32'(hs.empty), 1);
    hs.player_turn = 0;
    tick("mm.end");

    // Round beyond stored length fails without presses
    hs.check_round = 5'd5; hs.player_turn = 1;
    tick("long.start");
    chk("long.result", 32'(hs.result), 0);
    chk("long.empty", 32'(hs.empty), 1);
    hs.player_turn = 0;
    tick("long.end");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      clear       = ($urandom_range(0, 149) == 0);
      load_colour = ($urandom_range(0, 3) == 0);
      colour_in   = CW'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) begin
        if (!hs.player_turn) begin
          if ($urandom_range(0, 3) == 0)
            hs.check_round = RW'($urandom_range(0, 31));
          else
            hs.check_round = RW'($urandom_range(0, (q.size() > 31) ? 31 : q.size()));
        end
        hs.player_turn = ~hs.player_turn;
      end else if ($urandom_range(0, 19) == 0) begin
        hs.check_round = RW'($urandom_range(0, 31));
      end
      btn_valid = ($urandom_range(0, 1) == 1);
      if (m_active && $urandom_range(0, 19) != 0)
        btn_colour = CW'(q[m_pos]);
      else
        btn_colour = CW'($urandom_range(0, 3));
      tick("rand");
    end
    hs.player_turn = 0;
    tick("rand.end");

    // Fill to capacity, overflow ignored, then play all 32 entries
    clear = 1;
    tick("fill.clear");
    for (int i = 0; i < DEPTH + 1; i++) load($urandom_range(0, 3));
    chk("fill.seq_len", 32'(seq_len), 32);
    chk("fill.full", 32'(full), 1);
    hs.check_round = 5'd31; hs.player_turn = 1;
    tick("fill.start");
    for (int i = 0; i < DEPTH; i++) press(q[i], "fill.press");
    chk("fill.result", 32'(hs.result), 1);
    chk("fill.empty", 32'(hs.empty), 1);
    hs.player_turn = 0;
    tick("fill.end");

    // clear wins over a simultaneous load
    clear = 1; load_colour = 1; colour_in = 2'd1;
    tick("clrld");
    chk("clrld.seq_len", 32'(seq_len), 0);
    chk("clrld.full", 32'(full), 0);

    // Async reset between edges in the middle of a turn
    load(1); load(2); load(3);
    hs.check_round = 5'd2; hs.player_turn = 1;
    tick("arst.start");
    press(1, "arst.p1");
    #2;
    rst = 1; hs.player_turn = 0;
    #1;
    model_reset();
    check_all("arst.now");
    chk("arst.now.result", 32'(hs.result), 0);
    rst = 0;
    tick("arst.idle");
    load(3); load(1);
    hs.check_round = 5'd1; hs.player_turn = 1;
    tick("arst.restart");
    press(3, "arst.r1");
    press(1, "arst.r2");
    chk("arst.r2.result", 32'(hs.result), 1);
    chk("arst.r2.empty", 32'(hs.empty), 1);
    hs.player_turn = 0;
    tick("arst.end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
